// File: rtl/fetch_unit_if.sv
// Instruction-bus and decode-side signals of the fetch stage.
// The master modport is the fetch unit; the slave is the bus and decode.
interface fetch_unit_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misalign;

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_ok, iresp_data,
        output out_valid, out_pc, out_inst, out_misalign,
        input  out_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_ok, iresp_data,
        input  out_valid, out_pc, out_inst, out_misalign,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one read at a time, buffers one
// instruction for decode and squashes wrong-path fetches on redirect.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FLUSH,
        HOLD
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_pend_pc;
    logic        r_out_valid;
    logic [63:0] r_out_pc;
    logic [31:0] r_out_inst;
    logic        r_out_mis;

    state_t      w_nxt_state;
    logic [63:0] w_nxt_pc;
    logic [63:0] w_nxt_pend;
    logic [63:0] w_tgt;
    logic        w_go_req;
    logic        w_load;
    logic        w_clr;
    logic        w_fault;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pc    = r_pc;
        w_nxt_pend  = r_pend_pc;
        w_tgt       = r_pc;
        w_go_req    = 1'b0;
        w_load      = 1'b0;
        w_clr       = 1'b0;
        w_fault     = 1'b0;
        unique case (r_state)
            IDLE: w_go_req = 1'b1;
            REQ: begin
                if (redirect_valid && bus.iresp_ok) begin
                    w_go_req = 1'b1;
                    w_tgt    = redirect_pc;
                end else if (redirect_valid) begin
                    w_nxt_pend  = redirect_pc;
                    w_nxt_state = FLUSH;
                end else if (bus.iresp_ok) begin
                    w_load      = 1'b1;
                    w_nxt_state = HOLD;
                end
            end
            FLUSH: begin
                if (redirect_valid)
                    w_nxt_pend = redirect_pc;
                if (bus.iresp_ok) begin
                    w_go_req = 1'b1;
                    w_tgt    = redirect_valid ? redirect_pc : r_pend_pc;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    w_clr    = 1'b1;
                    w_go_req = 1'b1;
                    w_tgt    = redirect_pc;
                end else if (bus.out_ready && !r_out_mis) begin
                    w_clr    = 1'b1;
                    w_go_req = 1'b1;
                    w_tgt    = r_pc + 64'd4;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
        // A misaligned target never reaches the bus; it becomes a fault entry.
        if (w_go_req) begin
            w_nxt_pc = w_tgt;
            if (w_tgt[1:0] != 2'b00) begin
                w_fault     = 1'b1;
                w_nxt_state = HOLD;
            end else begin
                w_nxt_state = REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_pc      <= w_nxt_pc;
            r_pend_pc <= w_nxt_pend;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_inst  <= '0;
            r_out_mis   <= 1'b0;
        end else if (w_fault) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= w_tgt;
            r_out_inst  <= NOP_INST;
            r_out_mis   <= 1'b1;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_pc;
            r_out_inst  <= bus.iresp_data;
            r_out_mis   <= 1'b0;
        end else if (w_clr) begin
            r_out_valid <= 1'b0;
        end
    end

    logic w_busy;
    assign w_busy = (r_state == REQ) || (r_state == FLUSH);

    // In FLUSH the PC still holds the in-flight address.
    assign bus.ireq_valid   = w_busy;
    assign bus.ireq_addr    = w_busy ? r_pc : 64'd0;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_pc       = r_out_pc;
    assign bus.out_inst     = r_out_inst;
    assign bus.out_misalign = r_out_mis;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure,
// redirects in REQ/FLUSH/HOLD, misaligned targets and mid-flight reset.
module tb_fetch_unit;
    logic        clk;
    logic        reset_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    int          n_chk;
    int          n_fail;

    localparam logic [31:0] ADDI = 32'h00A0_0093;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Waits (bounded) for a request, checks its address stays put for
    // lat extra cycles, then answers with data.
    task automatic fetch_one(input logic [63:0] addr, input int lat,
                             input logic [31:0] data);
        for (int i = 0; i < 8 && !bus.ireq_valid; i++)
            tick();
        chk("req_valid", 64'(bus.ireq_valid), 64'd1);
        chk("req_addr", bus.ireq_addr, addr);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("req_hold", bus.ireq_addr, addr);
        end
        bus.iresp_ok   = 1'b1;
        bus.iresp_data = data;
        tick();
        bus.iresp_ok   = 1'b0;
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.iresp_ok   = 1'b0;
        bus.iresp_data = '0;
        bus.out_ready  = 1'b1;
        tick();
        tick();
        chk("rst_ovalid", 64'(bus.out_valid), 64'd0);
        chk("rst_opc", bus.out_pc, 64'd0);
        chk("rst_oinst", 64'(bus.out_inst), 64'd0);
        chk("rst_omis", 64'(bus.out_misalign), 64'd0);
        chk("rst_rvalid", 64'(bus.ireq_valid), 64'd0);
        chk("rst_raddr", bus.ireq_addr, 64'd0);

        reset_n = 1'b1;
        tick();
        chk("first_req", 64'(bus.ireq_valid), 64'd1);
        chk("first_addr", bus.ireq_addr, 64'h8000_0000);

        for (int k = 0; k < 3; k++) begin
            fetch_one(64'h8000_0000 + 64'(4 * k), 1, ADDI);
            chk("seq_ovalid", 64'(bus.out_valid), 64'd1);
            chk("seq_opc", bus.out_pc, 64'h8000_0000 + 64'(4 * k));
            chk("seq_oinst", 64'(bus.out_inst), 64'(ADDI));
            chk("seq_omis", 64'(bus.out_misalign), 64'd0);
            chk("seq_noreq", 64'(bus.ireq_valid), 64'd0);
        end

        tick();
        bus.out_ready = 1'b0;
        fetch_one(64'h8000_000C, 1, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ovalid", 64'(bus.out_valid), 64'd1);
            chk("bp_opc", bus.out_pc, 64'h8000_000C);
            chk("bp_oinst", 64'(bus.out_inst), 64'h1234_5678);
            chk("bp_noreq", 64'(bus.ireq_valid), 64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_next_v", 64'(bus.ireq_valid), 64'd1);
        chk("bp_next_a", bus.ireq_addr, 64'h8000_0010);

        bus.out_ready = 1'b0;
        fetch_one(64'h8000_0010, 0, ADDI);
        chk("hold_ovalid", 64'(bus.out_valid), 64'd1);
        redir(64'h8000_0008);
        chk("hredir_ovalid", 64'(bus.out_valid), 64'd0);
        chk("hredir_addr", bus.ireq_addr, 64'h8000_0008);

        redir(64'h8000_1000);
        chk("fl_valid", 64'(bus.ireq_valid), 64'd1);
        chk("fl_addr", bus.ireq_addr, 64'h8000_0008);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_hold", bus.ireq_addr, 64'h8000_0008);
        end
        bus.iresp_ok   = 1'b1;
        bus.iresp_data = 32'hDEAD_BEEF;
        tick();
        bus.iresp_ok = 1'b0;
        chk("fl_drop", 64'(bus.out_valid), 64'd0);
        chk("fl_newv", 64'(bus.ireq_valid), 64'd1);
        chk("fl_new", bus.ireq_addr, 64'h8000_1000);
        tick();
        chk("fl_drop2", 64'(bus.out_valid), 64'd0);

        redir(64'h0000_0300);
        redir(64'h0000_0100);
        redir(64'h0000_0200);
        chk("fl2_hold", bus.ireq_addr, 64'h8000_1000);
        bus.iresp_ok = 1'b1;
        tick();
        bus.iresp_ok = 1'b0;
        chk("fl2_latest", bus.ireq_addr, 64'h0000_0200);
        chk("fl2_ovalid", 64'(bus.out_valid), 64'd0);

        bus.iresp_ok = 1'b1;
        redir(64'h8000_0000);
        bus.iresp_ok = 1'b0;
        chk("rr_ovalid", 64'(bus.out_valid), 64'd0);
        chk("rr_addr", bus.ireq_addr, 64'h8000_0000);

        fetch_one(64'h8000_0000, 1, ADDI);
        redir(64'h8000_0002);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("mis_ovalid", 64'(bus.out_valid), 64'd1);
            chk("mis_opc", bus.out_pc, 64'h8000_0002);
            chk("mis_oinst", 64'(bus.out_inst), 64'h0000_0013);
            chk("mis_flag", 64'(bus.out_misalign), 64'd1);
            chk("mis_noreq", 64'(bus.ireq_valid), 64'd0);
            tick();
        end
        redir(64'h8000_0004);
        chk("mis_clr", 64'(bus.out_valid), 64'd0);
        chk("mis_addr", bus.ireq_addr, 64'h8000_0004);
        fetch_one(64'h8000_0004, 1, ADDI);
        chk("mis_rec_pc", bus.out_pc, 64'h8000_0004);
        chk("mis_rec_f", 64'(bus.out_misalign), 64'd0);

        tick();
        redir(64'h0000_0500);
        chk("rflush_v", 64'(bus.ireq_valid), 64'd1);
        chk("rflush_a", bus.ireq_addr, 64'h8000_0008);
        reset_n = 1'b0;
        #1;
        chk("arst_ovalid", 64'(bus.out_valid), 64'd0);
        chk("arst_rvalid", 64'(bus.ireq_valid), 64'd0);
        chk("arst_raddr", bus.ireq_addr, 64'd0);
        tick();
        reset_n      = 1'b1;
        bus.iresp_ok = 1'b1;
        tick();
        bus.iresp_ok = 1'b0;
        chk("stray_ovalid", 64'(bus.out_valid), 64'd0);
        chk("stray_addr", bus.ireq_addr, 64'h8000_0000);
        tick();
        chk("stray_ovalid2", 64'(bus.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 64-bit RISC-V core, directly upstream of decode.
- Owns the PC and issues 32-bit instruction reads on the instruction bus.
- Buffers one fetched instruction and presents it to decode through a valid/ready handshake.
- Accepts branch/jump redirects from execute, discarding wrong-path fetches, including ones still in flight.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word emitted with a misaligned-PC fault.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ireq_valid  out  1  instruction read request.
- ireq_addr  out  64  byte address of the request.
- iresp_ok  in  1  read data valid; completes the outstanding request.
- iresp_data  in  32  instruction word.
- redirect_valid  in  1  redirect PC from execute.
- redirect_pc  in  64  redirect target.
- out_valid  out  1  instruction buffer holds a valid instruction.
- out_ready  in  1  decode accepts the instruction.
- out_pc  out  64  PC of the buffered instruction.
- out_inst  out  32  buffered instruction word.
- out_misalign  out  1  buffered entry is an instruction-address-misaligned fault.

Behaviour:
- State: pc (64b), pending_pc (64b), 1-entry output buffer {out_pc, out_inst, out_misalign, out_valid}, FSM in {IDLE, REQ, FLUSH, HOLD}.
- Reset (async, reset_n=0): state=IDLE, pc=RESET_PC, out_valid=0, out_pc=0, out_inst=0, out_misalign=0, ireq_valid=0, ireq_addr=0.
- ireq_valid=1 exactly in REQ and FLUSH.
  - ireq_addr=pc in REQ; ireq_addr=the in-flight address in FLUSH.
  - Address is held stable until iresp_ok; a request is never withdrawn.
- IDLE: next cycle -> REQ. iresp_ok is ignored in IDLE.
- REQ:
  - redirect_valid & iresp_ok: drop data, pc=redirect_pc, stay REQ (new address next cycle).
  - redirect_valid & !iresp_ok: pending_pc=redirect_pc -> FLUSH.
  - iresp_ok only: buffer <= {pc, iresp_data, 0}, out_valid=1 next cycle -> HOLD.
  - Fetch latency: 1 cycle from iresp_ok to out_valid.
- FLUSH:
  - redirect_valid overwrites pending_pc (latest wins).
  - On iresp_ok: drop data, pc=pending_pc (or redirect_pc if a redirect arrives the same cycle) -> REQ.
- HOLD (out_valid=1; outputs stable until handshake):
  - redirect_valid: out_valid=0 next cycle, pc=redirect_pc -> REQ. Redirect beats out_ready, and the entry is not counted as consumed.
  - out_valid & out_ready: pc=pc+4 (64-bit wrap) -> REQ, out_valid=0 next cycle.
  - Throughput: at most one instruction per 3 cycles with a 1-cycle bus (no prefetch).
- Misalignment, checked whenever entering REQ with pc[1:0]!=0:
  - No bus request is made; go directly to HOLD with buffer {pc, NOP_INST, 1}.
  - On handshake, pc stays unchanged and the FSM re-enters HOLD with the same fault entry.
  - Only a redirect clears the fault.
  - RESET_PC must be 4-byte aligned.
- Buffer outputs are registered, with no combinational path from out_ready/redirect to out_*.
- ireq_* is a function of FSM state and registers only.
- Reset mid-operation:
  - Any outstanding request is abandoned from the core's side.
  - The bus must drop it; a stray iresp_ok in IDLE is ignored.
  - The buffer is cleared.

Test Plan:
- Reset release, bus answers 1 cycle after each request with 32'h00A00093, out_ready=1:
  - First ireq_addr=0x8000_0000 in cycle 1 after IDLE.
  - out_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; out_inst=00A00093; out_misalign=0.
- Backpressure: out_ready=0 for 5 cycles in HOLD:
  - out_valid/out_pc/out_inst stay constant and ireq_valid=0.
  - On out_ready=1, the next ireq_addr is out_pc+4.
- Redirect to 0x8000_1000 while a request to 0x8000_0008 is outstanding (bus delays 4 cycles):
  - ireq_addr stays 0x8000_0008 until iresp_ok and its data is never presented.
  - Next ireq_addr=0x8000_1000.
- Two redirects during FLUSH (0x100 then 0x200):
  - After iresp_ok, the next ireq_addr=0x200.
- Redirect to 0x8000_0002:
  - No request issued.
  - out_valid=1, out_pc=0x8000_0002, out_inst=00000013, out_misalign=1, repeating until redirect to 0x8000_0004 restores normal fetch.
- reset_n pulsed low while in FLUSH:
  - out_valid=0 immediately.
  - pc=RESET_PC; a stray iresp_ok in IDLE causes no output.
